// File: rtl/search_arbiter_pkg.sv
// Shared types and default parameters for the search arbiter.
// Optional watchdog feature is enabled with SEARCH_TIMEOUT_EN.
package search_arbiter_pkg;

   localparam int DW_DEF      = 8;
   localparam int AW_DEF      = 5;
   localparam int TMO_CYC_DEF = 63;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_CAPT = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   // Counter width able to hold values up to and including limit.
   function automatic int cnt_width(input int limit);
      int w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/search_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
// The priority pointer only moves when a grant is committed.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_commit,
   output logic [1:0] o_gnt
);

   logic r_prio1;   // 1: requester 1 wins a tie

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_prio1 ? 2'b10 : 2'b01;
         default: o_gnt = 2'b00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prio1 <= 1'b0;
      end else if (i_commit && (o_gnt != 2'b00)) begin
         r_prio1 <= o_gnt[0];
      end
   end

endmodule

// File: rtl/search_arbiter.sv
// Arbitrates two search requesters onto one search engine and shares the
// memory port with a loader. Define SEARCH_TIMEOUT_EN to add a RUN watchdog.
module search_arbiter
   import search_arbiter_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req0_valid,
   input  logic          i_req1_valid,
   input  logic [DW-1:0] i_req0_tgt,
   input  logic [DW-1:0] i_req1_tgt,
   output logic          o_req0_ready,
   output logic          o_req1_ready,
   output logic          o_eng_s,
   output logic [DW-1:0] o_eng_tin,
   input  logic          i_eng_done,
   input  logic          i_eng_found,
   input  logic [AW-1:0] i_eng_addf,
   input  logic [AW-1:0] i_eng_addo,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   output logic          o_wr_ready,
   output logic [AW-1:0] o_mem_addr,
   output logic          o_mem_we,
   output logic [DW-1:0] o_mem_wdata,
   output logic          o_rsp_valid,
   output logic          o_rsp_id,
   output logic          o_rsp_found,
   output logic [AW-1:0] o_rsp_addr,
   output logic          o_rsp_timeout,
   input  logic          i_rsp_ready
);

   if (TMO_CYC < 1) begin : g_tmo_range_chk
      $error("TMO_CYC must be at least 1");
   end

   state_t        r_state;
   state_t        w_state_next;
   logic [DW-1:0] r_tgt;
   logic          r_id;
   logic          r_found;
   logic [AW-1:0] r_addr;

   logic          w_idle;
   logic          w_grant_en;
   logic          w_grant_fire;
   logic [1:0]    w_gnt;
   logic          w_tmo_hit;
   logic          w_tmo_flag;
   logic          w_capt_found;

   // Requester-facing outputs are gated by reset so everything reads 0 while held.
   assign w_idle       = (r_state == ST_IDLE) && i_rst_n;
   assign w_grant_en   = w_idle && !i_wr_en;
   assign w_grant_fire = w_grant_en && (w_gnt != 2'b00);

   rr_arb2 u_arb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_req    ({i_req1_valid, i_req0_valid} & {2{w_grant_en}}),
      .i_commit (w_grant_fire),
      .o_gnt    (w_gnt)
   );

`ifdef SEARCH_TIMEOUT_EN
   localparam int CW = cnt_width(TMO_CYC);

   logic [CW-1:0] r_tmo_cnt;
   logic          r_tmo_flag;
   logic          r_timeout;

   // Cleared while in LOAD so the first RUN cycle sees 0; hit on the TMO_CYC-th RUN cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmo_cnt  <= '0;
         r_tmo_flag <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (r_state == ST_LOAD) begin
            r_tmo_cnt  <= '0;
            r_tmo_flag <= 1'b0;
         end else if (r_state == ST_RUN) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_tmo_hit) begin
               r_tmo_flag <= 1'b1;
            end
         end
         if (r_state == ST_CAPT) begin
            r_timeout <= r_tmo_flag;
         end
      end
   end

   assign w_tmo_hit     = (r_state == ST_RUN) && !i_eng_done &&
                          (r_tmo_cnt == CW'(TMO_CYC - 1));
   assign w_tmo_flag    = r_tmo_flag;
   assign o_rsp_timeout = r_timeout;
`else
   assign w_tmo_hit     = 1'b0;
   assign w_tmo_flag    = 1'b0;
   assign o_rsp_timeout = 1'b0;
`endif

   assign w_capt_found = i_eng_found && !w_tmo_flag;

   always_comb begin
      w_state_next = r_state;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      o_wr_ready   = 1'b0;
      o_eng_s      = 1'b0;
      o_eng_tin    = '0;
      o_mem_addr   = '0;
      o_mem_we     = 1'b0;
      o_mem_wdata  = '0;
      o_rsp_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_idle && i_wr_en) begin
               o_wr_ready  = 1'b1;
               o_mem_we    = 1'b1;
               o_mem_addr  = i_wr_addr;
               o_mem_wdata = i_wr_data;
            end else if (w_grant_fire) begin
               o_req0_ready = w_gnt[0];
               o_req1_ready = w_gnt[1];
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_eng_tin    = r_tgt;
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            o_eng_s    = 1'b1;
            o_eng_tin  = r_tgt;
            o_mem_addr = i_eng_addo;
            if (i_eng_done || w_tmo_hit) begin
               w_state_next = ST_CAPT;
            end
         end
         ST_CAPT: begin
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_tgt   <= '0;
         r_id    <= 1'b0;
         r_found <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_grant_fire) begin
            r_tgt <= w_gnt[1] ? i_req1_tgt : i_req0_tgt;
            r_id  <= w_gnt[1];
         end
         // A miss or a watchdog expiry reports address 0.
         if (r_state == ST_CAPT) begin
            r_found <= w_capt_found;
            r_addr  <= w_capt_found ? i_eng_addf : '0;
         end
      end
   end

   assign o_rsp_id    = r_id;
   assign o_rsp_found = r_found;
   assign o_rsp_addr  = r_addr;

endmodule

// File: tb/tb_search_arbiter.sv
// Scoreboard bench for search_arbiter with a behavioural search engine.
// Timeout scenario adapts to SEARCH_TIMEOUT_EN.
module tb_search_arbiter;

   localparam int DW  = 8;
   localparam int AW  = 5;
   localparam int TMO = 63;

   typedef struct packed {
      logic          id;
      logic          found;
      logic [AW-1:0] addr;
      logic          tmo;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic [DW-1:0] req0_tgt, req1_tgt;
   logic          req0_ready, req1_ready;
   logic          eng_s;
   logic [DW-1:0] eng_tin;
   logic          eng_done  = 1'b0;
   logic          eng_found = 1'b0;
   logic [AW-1:0] eng_addf  = '0;
   logic [AW-1:0] eng_addo;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic          rsp_valid, rsp_id, rsp_found, rsp_timeout;
   logic [AW-1:0] rsp_addr;
   logic          rsp_ready;

   rsp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // engine model configuration
   int            eng_lat   = 1;
   logic          eng_hang  = 1'b0;
   logic          cfg_found = 1'b0;
   logic [AW-1:0] cfg_addf  = '0;
   int            eng_cnt   = 0;

   always #5 clk = ~clk;

   search_arbiter #(.DW(DW), .AW(AW), .TMO_CYC(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
      .i_req0_tgt(req0_tgt), .i_req1_tgt(req1_tgt),
      .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
      .o_eng_s(eng_s), .o_eng_tin(eng_tin),
      .i_eng_done(eng_done), .i_eng_found(eng_found), .i_eng_addf(eng_addf),
      .i_eng_addo(eng_addo),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_wr_ready(wr_ready),
      .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_found(rsp_found),
      .o_rsp_addr(rsp_addr), .o_rsp_timeout(rsp_timeout),
      .i_rsp_ready(rsp_ready)
   );

   // Engine: done rises eng_lat cycles after eng_s rises; results persist after eng_s drops.
   always @(posedge clk) begin
      if (!eng_s) begin
         eng_cnt  <= 0;
         eng_done <= 1'b0;
      end else begin
         eng_cnt <= eng_cnt + 1;
         if (!eng_hang && (eng_cnt + 1 >= eng_lat)) begin
            eng_done  <= 1'b1;
            eng_found <= cfg_found;
            eng_addf  <= cfg_addf;
         end
      end
   end
   assign eng_addo = eng_cnt[AW-1:0];

   // Waits (at negedges) for rsp_valid; performs no comparisons.
   task automatic wait_rsp(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok = 1'b0;
      while (cycles < budget) begin
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic accept_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else n_pass++;
      n_checks++; if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready: got %b want 0", req0_ready); else n_pass++;
      n_checks++; if (req1_ready !== 1'b0) $display("FAIL reset_req1_ready: got %b want 0", req1_ready); else n_pass++;
      n_checks++; if (eng_s !== 1'b0) $display("FAIL reset_eng_s: got %b want 0", eng_s); else n_pass++;
      n_checks++; if (mem_we !== 1'b0 || mem_addr !== '0) $display("FAIL reset_mem: got we=%b addr=%h want 0/0", mem_we, mem_addr); else n_pass++;
      n_checks++; if ({rsp_valid, rsp_id, rsp_found, rsp_addr, rsp_timeout} !== '0) $display("FAIL reset_rsp: got %b want 0", {rsp_valid, rsp_id, rsp_found, rsp_addr, rsp_timeout}); else n_pass++;
      wr_en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_search();
      int cyc; bit ok; rsp_t e;
      eng_lat = 10; cfg_found = 1'b1; cfg_addf = 5'd7; eng_hang = 1'b0;
      req0_valid = 1'b1; req0_tgt = 8'h2A; #1;
      n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL single_grant: got %b%b want 01", req1_ready, req0_ready); else n_pass++;
      exp_q.push_back(rsp_t'{1'b0, 1'b1, 5'd7, 1'b0});
      @(negedge clk); req0_valid = 1'b0; #1;
      n_checks++; if (req0_ready !== 1'b0) $display("FAIL single_ready_pulse: got %b want 0", req0_ready); else n_pass++;
      n_checks++; if (eng_s !== 1'b0 || eng_tin !== 8'h2A) $display("FAIL single_load: got s=%b tin=%h want 0/2a", eng_s, eng_tin); else n_pass++;
      n_checks++; if (mem_addr !== '0 || mem_we !== 1'b0) $display("FAIL single_load_mem: got addr=%h we=%b want 0/0", mem_addr, mem_we); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (eng_s !== 1'b1 || eng_tin !== 8'h2A) $display("FAIL single_run: got s=%b tin=%h want 1/2a", eng_s, eng_tin); else n_pass++;
      n_checks++; if (mem_addr !== eng_addo || mem_we !== 1'b0) $display("FAIL single_run_mem: got addr=%h we=%b want %h/0", mem_addr, mem_we, eng_addo); else n_pass++;
      @(negedge clk);
      wait_rsp(60, cyc, ok);
      n_checks++; if (!ok) $display("FAIL single_rsp_timeout: got no rsp_valid want rsp_valid within 60 cycles"); else n_pass++;
      n_checks++; if (cyc + 3 != eng_lat + 4) $display("FAIL single_latency: got %0d want %0d", cyc + 3, eng_lat + 4); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      n_checks++; if ({rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL single_rsp: got %h want %h", {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
      n_checks++; if (eng_s !== 1'b0) $display("FAIL single_resp_eng_s: got %b want 0", eng_s); else n_pass++;
      accept_rsp(); #1;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int cyc; bit ok; rsp_t e;
      pulse_reset();
      eng_lat = 3; cfg_found = 1'b0; cfg_addf = 5'd9;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_tgt = 8'h11; req1_tgt = 8'h22; #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL b2b_grant0: got %b want 01", {req1_ready, req0_ready}); else n_pass++;
      exp_q.push_back(rsp_t'{1'b0, 1'b0, 5'd0, 1'b0});
      @(negedge clk); #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b00 || eng_tin !== 8'h11) $display("FAIL b2b_load0: got rdy=%b tin=%h want 00/11", {req1_ready, req0_ready}, eng_tin); else n_pass++;
      wait_rsp(40, cyc, ok);
      n_checks++; if (!ok) $display("FAIL b2b_rsp0_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      n_checks++; if ({rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL b2b_rsp0: got %h want %h", {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
      cfg_found = 1'b1; cfg_addf = 5'h1F;
      accept_rsp(); #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL b2b_grant1: got %b want 10", {req1_ready, req0_ready}); else n_pass++;
      exp_q.push_back(rsp_t'{1'b1, 1'b1, 5'h1F, 1'b0});
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; #1;
      n_checks++; if (eng_tin !== 8'h22) $display("FAIL b2b_load1: got tin=%h want 22", eng_tin); else n_pass++;
      wait_rsp(40, cyc, ok);
      n_checks++; if (!ok) $display("FAIL b2b_rsp1_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      n_checks++; if ({rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL b2b_rsp1: got %h want %h", {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
      accept_rsp();
   endtask

   task automatic test_write_priority();
      int cyc; bit ok; rsp_t e;
      eng_lat = 2; cfg_found = 1'b1; cfg_addf = 5'd3;
      wr_en = 1'b1; wr_addr = 5'h1F; wr_data = 8'h55; req1_valid = 1'b1; req1_tgt = 8'h33; #1;
      n_checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b1) $display("FAIL wr_accept: got rdy=%b we=%b want 1/1", wr_ready, mem_we); else n_pass++;
      n_checks++; if (mem_addr !== 5'h1F || mem_wdata !== 8'h55) $display("FAIL wr_port: got addr=%h data=%h want 1f/55", mem_addr, mem_wdata); else n_pass++;
      n_checks++; if (req1_ready !== 1'b0) $display("FAIL wr_blocks_grant: got %b want 0", req1_ready); else n_pass++;
      @(negedge clk); wr_en = 1'b0; #1;
      n_checks++; if (req1_ready !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b0) $display("FAIL wr_next_grant: got rdy1=%b wr_rdy=%b we=%b want 1/0/0", req1_ready, wr_ready, mem_we); else n_pass++;
      exp_q.push_back(rsp_t'{1'b1, 1'b1, 5'd3, 1'b0});
      @(negedge clk); req1_valid = 1'b0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'hA5; #1;
      n_checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) $display("FAIL wr_held_busy: got rdy=%b we=%b addr=%h want 0/0/0", wr_ready, mem_we, mem_addr); else n_pass++;
      wait_rsp(40, cyc, ok);
      n_checks++; if (!ok) $display("FAIL wr_rsp_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      n_checks++; if ({rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL wr_rsp: got %h want %h", {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
      n_checks++; if (wr_ready !== 1'b0) $display("FAIL wr_held_resp: got %b want 0", wr_ready); else n_pass++;
      accept_rsp(); #1;
      n_checks++; if (wr_ready !== 1'b1 || mem_addr !== 5'd4 || mem_wdata !== 8'hA5) $display("FAIL wr_held_accept: got rdy=%b addr=%h data=%h want 1/04/a5", wr_ready, mem_addr, mem_wdata); else n_pass++;
      @(negedge clk); wr_en = 1'b0;
   endtask

   task automatic test_rsp_stall();
      int cyc; bit ok; rsp_t e;
      eng_lat = 1; cfg_found = 1'b1; cfg_addf = 5'h12;
      req0_valid = 1'b1; req0_tgt = 8'h44; #1;
      n_checks++; if (req0_ready !== 1'b1) $display("FAIL stall_grant: got %b want 1", req0_ready); else n_pass++;
      exp_q.push_back(rsp_t'{1'b0, 1'b1, 5'h12, 1'b0});
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b1; req1_tgt = 8'h55;
      wait_rsp(40, cyc, ok);
      n_checks++; if (!ok) $display("FAIL stall_rsp_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_checks++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL stall_hold%0d: got v=%b %h want 1 %h", i, rsp_valid, {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
         n_checks++; if (req1_ready !== 1'b0) $display("FAIL stall_no_grant%0d: got %b want 0", i, req1_ready); else n_pass++;
      end
      accept_rsp(); #1;
      n_checks++; if (req1_ready !== 1'b1) $display("FAIL stall_after_grant: got %b want 1", req1_ready); else n_pass++;
      exp_q.push_back(rsp_t'{1'b1, 1'b1, 5'h12, 1'b0});
      @(negedge clk); req1_valid = 1'b0;
      wait_rsp(40, cyc, ok);
      n_checks++; if (!ok) $display("FAIL stall_rsp2_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      n_checks++; if ({rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL stall_rsp2: got %h want %h", {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
      accept_rsp();
   endtask

   task automatic test_timeout();
      int cyc; bit ok; rsp_t e; int run;
      eng_hang = 1'b1; cfg_found = 1'b1; cfg_addf = 5'd5; eng_lat = 1;
      req0_valid = 1'b1; req0_tgt = 8'h66; #1;
      n_checks++; if (req0_ready !== 1'b1) $display("FAIL tmo_grant: got %b want 1", req0_ready); else n_pass++;
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk);
      run = 0;
`ifdef SEARCH_TIMEOUT_EN
      exp_q.push_back(rsp_t'{1'b0, 1'b0, 5'd0, 1'b1});
      while (eng_s === 1'b1 && run < 200) begin
         run++;
         @(negedge clk);
      end
      n_checks++; if (run != TMO) $display("FAIL tmo_run_cycles: got %0d want %0d", run, TMO); else n_pass++;
`else
      while (eng_s === 1'b1 && rsp_valid !== 1'b1 && run < 100) begin
         run++;
         @(negedge clk);
      end
      n_checks++; if (run != 100 || eng_s !== 1'b1) $display("FAIL tmo_waits: got run=%0d s=%b want 100/1", run, eng_s); else n_pass++;
      exp_q.push_back(rsp_t'{1'b0, 1'b1, 5'd5, 1'b0});
      eng_hang = 1'b0;
`endif
      wait_rsp(40, cyc, ok);
      n_checks++; if (!ok) $display("FAIL tmo_rsp_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      n_checks++; if ({rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL tmo_rsp: got %h want %h", {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
      n_checks++; if (eng_s !== 1'b0) $display("FAIL tmo_eng_s: got %b want 0", eng_s); else n_pass++;
      accept_rsp();
      eng_hang = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int cyc; bit ok; rsp_t e; int seen;
      eng_lat = 20; cfg_found = 1'b1; cfg_addf = 5'd2;
      req0_valid = 1'b1; req0_tgt = 8'h77; #1;
      n_checks++; if (req0_ready !== 1'b1) $display("FAIL rstrun_grant: got %b want 1", req0_ready); else n_pass++;
      @(negedge clk); req0_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      n_checks++; if (eng_s !== 1'b1) $display("FAIL rstrun_in_run: got %b want 1", eng_s); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (eng_s !== 1'b0) $display("FAIL rstrun_async_eng_s: got %b want 0", eng_s); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0 || mem_addr !== '0) $display("FAIL rstrun_outputs: got v=%b addr=%h want 0/0", rsp_valid, mem_addr); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen++;
      end
      n_checks++; if (seen != 0) $display("FAIL rstrun_no_rsp: got %0d rsp cycles want 0", seen); else n_pass++;
      eng_lat = 2; cfg_addf = 5'h0A;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_tgt = 8'h01; req1_tgt = 8'h02; #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rstrun_ptr: got %b want 01", {req1_ready, req0_ready}); else n_pass++;
      exp_q.push_back(rsp_t'{1'b0, 1'b1, 5'h0A, 1'b0});
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(40, cyc, ok);
      n_checks++; if (!ok) $display("FAIL rstrun_rsp_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else n_pass++;
      e = exp_q.pop_front();
      $display("rsp id=%0d found=%0d addr=%0d tmo=%0d", rsp_id, rsp_found, rsp_addr, rsp_timeout);
      n_checks++; if ({rsp_id, rsp_found, rsp_addr, rsp_timeout} !== e) $display("FAIL rstrun_rsp: got %h want %h", {rsp_id, rsp_found, rsp_addr, rsp_timeout}, e); else n_pass++;
      accept_rsp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; req0_tgt = '0; req1_tgt = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
      test_reset();
      test_single_search();
      test_back_to_back();
      test_write_priority();
      test_rsp_stall();
      test_timeout();
      test_reset_mid_run();
      n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
